// File: rtl/alu_sequencer_if.sv
// Signal bundle between the switch/button front end, alu_sequencer and the 8-bit ALU.
// The slave modport is the sequencer's view. The master modport is the front end plus the ALU.
interface alu_sequencer_if #(
    parameter int unsigned AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [11:0]   prog_data;
    logic [AW:0]   count;
    logic          start;
    logic          halt;
    logic [7:0]    alu_y;
    logic [3:0]    alu_selector;
    logic [7:0]    alu_data;
    logic          alu_enable;
    logic [7:0]    result;
    logic          result_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output prog_we, prog_addr, prog_data, count, start, halt, alu_y,
        input  alu_selector, alu_data, alu_enable, result, result_valid, pc, busy, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, count, start, halt, alu_y,
        output alu_selector, alu_data, alu_enable, result, result_valid, pc, busy, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Plays a stored program of {selector, operand} words into the ALU, one enable pulse per slot,
// and captures Y after a fixed settle time.
module alu_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic           i_clock,
    input  logic           i_reset,
    alu_sequencer_if.slave bus
);
    localparam int unsigned HW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_pc, w_pc_nx;
    logic [AW:0]   r_n, w_n_nx;
    logic [HW-1:0] r_hold, w_hold_nx;
    logic [3:0]    r_sel, w_sel_nx;
    logic [7:0]    r_data, w_data_nx;
    logic [7:0]    r_result, w_result_nx;
    logic          r_err, w_err_nx;
    logic [11:0]   r_mem [DEPTH];

    logic          w_busy;
    logic          w_mem_we;
    logic          w_last_hold;
    logic          w_last_slot;
    logic [11:0]   w_slot0;
    logic [11:0]   w_next_slot;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign w_last_hold = (r_hold == HW'(SETTLE - 1));
    assign w_last_slot = ({1'b0, r_pc} == (r_n - ONE_W));
    // A write to slot 0 in the start cycle must be the first command issued.
    assign w_slot0     = (bus.prog_we && (bus.prog_addr == '0)) ? bus.prog_data : r_mem[0];
    assign w_next_slot = r_mem[r_pc + AW'(1)];

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_n_nx      = r_n;
        w_hold_nx   = r_hold;
        w_sel_nx    = r_sel;
        w_data_nx   = r_data;
        w_result_nx = r_result;
        w_err_nx    = r_err;
        w_mem_we    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mem_we = bus.prog_we;
                if (bus.start && !bus.halt) begin
                    if (bus.count == '0) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_state_nx = S_SETUP;
                        w_pc_nx    = '0;
                        w_n_nx     = (bus.count > DEPTH_W) ? DEPTH_W : bus.count;
                        w_err_nx   = 1'b0;
                        w_sel_nx   = w_slot0[11:8];
                        w_data_nx  = w_slot0[7:0];
                    end
                end
            end
            S_SETUP: w_state_nx = S_PULSE;
            S_PULSE: begin
                w_state_nx = S_HOLD;
                w_hold_nx  = '0;
            end
            S_HOLD: begin
                if (w_last_hold) begin
                    w_state_nx  = S_CAPTURE;
                    w_result_nx = bus.alu_y;
                end else begin
                    w_hold_nx = r_hold + HW'(1);
                end
            end
            S_CAPTURE: begin
                if (w_last_slot) begin
                    w_state_nx = S_FINISH;
                end else begin
                    w_state_nx = S_SETUP;
                    w_pc_nx    = r_pc + AW'(1);
                    w_sel_nx   = w_next_slot[11:8];
                    w_data_nx  = w_next_slot[7:0];
                end
            end
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase

        // Commands arriving mid-run are dropped and flagged; halt overrides any transition,
        // including a capture that would otherwise land on this edge.
        if (w_busy) begin
            if (bus.prog_we || bus.start) begin
                w_err_nx = 1'b1;
            end
            if (bus.halt) begin
                w_state_nx  = S_IDLE;
                w_result_nx = r_result;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_n      <= '0;
            r_hold   <= '0;
            r_sel    <= '0;
            r_data   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_n      <= w_n_nx;
            r_hold   <= w_hold_nx;
            r_sel    <= w_sel_nx;
            r_data   <= w_data_nx;
            r_result <= w_result_nx;
            r_err    <= w_err_nx;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset && w_mem_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.alu_selector = r_sel;
    assign bus.alu_data     = r_data;
    assign bus.alu_enable   = (r_state == S_PULSE);
    assign bus.result       = r_result;
    assign bus.result_valid = (r_state == S_CAPTURE);
    assign bus.pc           = r_pc;
    assign bus.busy         = w_busy;
    assign bus.done         = (r_state == S_FINISH);
    assign bus.err          = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: a stand-in ALU is attached, and every run is scored
// against program/ALU expectations and slot timing computed from the cycle budget.
module tb_alu_sequencer;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned SETTLE = 2;
    localparam int          SLOT   = SETTLE + 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    alu_sequencer_if #(.AW(AW)) bus ();

    alu_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .SETTLE(SETTLE)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Stand-in ALU: A/B operand registers and result Y, updated on the enable pulse.
    logic [7:0] alu_a, alu_b, alu_yr;
    logic [7:0] ini_a, ini_b, ini_y;
    logic       alu_clr;

    always @(posedge clk) begin
        if (alu_clr) begin
            alu_a  <= ini_a;
            alu_b  <= ini_b;
            alu_yr <= ini_y;
        end else if (bus.alu_enable) begin
            case (bus.alu_selector)
                4'hF: alu_a <= bus.alu_data;
                4'hE: begin alu_a <= alu_b; alu_b <= alu_a; end
                4'hD: alu_b <= alu_a;
                4'h0: alu_yr <= alu_a + alu_b;
                4'h1: alu_yr <= alu_a - alu_b;
                4'h2: alu_yr <= alu_a & alu_b;
                4'h3: alu_yr <= alu_a | alu_b;
                4'h4: alu_yr <= alu_a ^ alu_b;
                default: alu_yr <= alu_a ^ bus.alu_data;
            endcase
        end
    end
    assign bus.alu_y = alu_yr;

    // Reference: program image plus the Y expected after each executed slot.
    logic [11:0] prog_m [DEPTH];
    logic [7:0]  exp_y  [DEPTH];
    logic [7:0]  last_res;

    task automatic ref_model(input int n);
        logic [7:0] a, b, y, d;
        logic [3:0] s;
        a = ini_a; b = ini_b; y = ini_y;
        for (int j = 0; j < n; j++) begin
            s = prog_m[j][11:8];
            d = prog_m[j][7:0];
            if (s == 4'hF)      a = d;
            else if (s == 4'hE) {a, b} = {b, a};
            else if (s == 4'hD) b = a;
            else if (s == 4'h0) y = a + b;
            else if (s == 4'h1) y = a - b;
            else if (s == 4'h2) y = a & b;
            else if (s == 4'h3) y = a | b;
            else if (s == 4'h4) y = a ^ b;
            else                y = a ^ d;
            exp_y[j] = y;
        end
    endtask

    // Monitor: collects pulses, captures and done pulses; checks pulse width and operand stability.
    int          q_pcyc [$];
    logic [11:0] q_pcmd [$];
    int          q_ppc  [$];
    int          q_rcyc [$];
    logic [7:0]  q_rval [$];
    int          q_dcyc [$];
    logic        mon_en;
    logic        prev_en;
    logic [11:0] prev_cmd;
    logic [11:0] stab_v;
    int          stab_n = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.alu_enable) begin
                check("pulse_width", 32'(prev_en), 32'd0);
                check("pre_stable", 32'(prev_cmd), 32'({bus.alu_selector, bus.alu_data}));
                q_pcyc.push_back(cyc);
                q_pcmd.push_back({bus.alu_selector, bus.alu_data});
                q_ppc.push_back(int'(bus.pc));
                stab_v = {bus.alu_selector, bus.alu_data};
                stab_n = SETTLE;
            end else if (stab_n > 0) begin
                check("post_stable", 32'({bus.alu_selector, bus.alu_data}), 32'(stab_v));
                stab_n--;
            end
            if (bus.result_valid) begin
                q_rcyc.push_back(cyc);
                q_rval.push_back(bus.result);
            end
            if (bus.done) q_dcyc.push_back(cyc);
        end else begin
            stab_n = 0;
        end
        prev_en  = bus.alu_enable;
        prev_cmd = {bus.alu_selector, bus.alu_data};
    end

    function automatic logic [28:0] all_outs();
        return {bus.alu_selector, bus.alu_data, bus.alu_enable, bus.result, bus.result_valid,
                bus.pc, bus.busy, bus.done, bus.err};
    endfunction

    task automatic clear_queues();
        q_pcyc.delete(); q_pcmd.delete(); q_ppc.delete();
        q_rcyc.delete(); q_rval.delete(); q_dcyc.delete();
    endtask

    task automatic write_slot(input int addr, input logic [11:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(addr);
        bus.prog_data = data;
        prog_m[addr]  = data;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(DEPTH); i++) write_slot(i, 12'($urandom));
    endtask

    // One run: halt_at / err_at are cycle offsets from the start cycle (0 = none).
    task automatic run(input int cnt, input int halt_at, input int err_at,
                       input bit err_start, input bit wr0);
        int n, t_s, te, np, nr;
        logic [11:0] w0;
        n = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
        @(negedge clk);
        ini_a = 8'($urandom); ini_b = 8'($urandom); ini_y = 8'($urandom);
        alu_clr = 1'b1;
        @(negedge clk);
        alu_clr = 1'b0;
        clear_queues();
        mon_en    = 1'b1;
        bus.start = 1'b1;
        bus.count = (AW + 1)'(cnt);
        if (wr0) begin
            w0 = 12'($urandom);
            bus.prog_we   = 1'b1;
            bus.prog_addr = '0;
            bus.prog_data = w0;
            prog_m[0]     = w0;
        end
        t_s = cyc;
        ref_model(n);
        te = (halt_at > 0) ? t_s + halt_at : t_s + n * SLOT + 10;

        for (int c = 1; c <= n * SLOT + 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.prog_we = 1'b0; bus.halt = 1'b0;
            if (c == 1) begin
                check("busy_on", 32'(bus.busy), 32'd1);
                check("err_clr", 32'(bus.err), 32'd0);
            end
            if (halt_at > 0 && c == halt_at + 1)
                check("halt_idle", 32'({bus.busy, bus.alu_enable, bus.done}), 32'd0);
            if (halt_at == 0 && c == n * SLOT + 1)
                check("finish_busy", 32'(bus.busy), 32'd0);
            if (c == err_at) begin
                if (err_start) begin
                    bus.start = 1'b1;
                    bus.count = (AW + 1)'($urandom_range(31, 1));
                end else begin
                    bus.prog_we   = 1'b1;
                    bus.prog_addr = AW'($urandom);
                    bus.prog_data = 12'($urandom);
                end
            end
            if (c == halt_at) bus.halt = 1'b1;
        end

        np = 0; nr = 0;
        for (int j = 0; j < n; j++) begin
            if (t_s + 2 + j * SLOT <= te) np++;
            if (t_s + (j + 1) * SLOT <= te) nr++;
        end
        check("n_pulse", 32'(q_pcyc.size()), 32'(np));
        for (int j = 0; j < np && j < q_pcyc.size(); j++) begin
            check("pulse_cyc", 32'(q_pcyc[j] - t_s), 32'(2 + j * SLOT));
            check("pulse_cmd", 32'(q_pcmd[j]), 32'(prog_m[j]));
            check("pulse_pc", 32'(q_ppc[j]), 32'(j));
        end
        check("n_result", 32'(q_rcyc.size()), 32'(nr));
        for (int j = 0; j < nr && j < q_rcyc.size(); j++) begin
            check("result_cyc", 32'(q_rcyc[j] - t_s), 32'((j + 1) * SLOT));
            check("result_val", 32'(q_rval[j]), 32'(exp_y[j]));
        end
        if (nr > 0) last_res = exp_y[nr - 1];
        check("n_done", 32'(q_dcyc.size()), (halt_at > 0) ? 32'd0 : 32'd1);
        if (halt_at == 0 && q_dcyc.size() > 0)
            check("done_cyc", 32'(q_dcyc[0] - t_s), 32'(n * SLOT + 1));
        check("result_hold", 32'(bus.result), 32'(last_res));
        check("err_end", 32'(bus.err), (err_at > 0) ? 32'd1 : 32'd0);
        if (halt_at == 0) check("pc_end", 32'(bus.pc), 32'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, n, h, e;
        rst_n = 1'b0; alu_clr = 1'b1; mon_en = 1'b0;
        ini_a = '0; ini_b = '0; ini_y = '0; last_res = '0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.count = 5'd4; bus.start = 1'b1; bus.halt = 1'b0;

        // Reset held with start asserted: everything stays at zero.
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", 32'(all_outs()), 32'd0);
        end
        bus.start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        alu_clr = 1'b0;
        check("post_reset", 32'(all_outs()), 32'd0);

        // Load A, swap, load A, add.
        write_slot(0, 12'hF05); write_slot(1, 12'hE00);
        write_slot(2, 12'hF03); write_slot(3, 12'h000);
        run(4, 0, 0, 1'b0, 1'b0);
        check("load_add_result", 32'(bus.result), 32'h08);

        // Error cases: zero count, then a write while busy, then a clean start clears err.
        load_random();
        @(negedge clk);
        bus.start = 1'b1; bus.count = '0;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_count_err", 32'({bus.err, bus.busy}), 32'b10);
        run(4, 0, 3, 1'b0, 1'b0);
        run(16, 0, 0, 1'b0, 1'b0);
        run(5, 0, 7, 1'b1, 1'b0);

        // Halt in the second slot's first HOLD cycle.
        run(4, SLOT + 3, 0, 1'b0, 1'b0);

        // Count above DEPTH clamps to DEPTH slots.
        run(31, 0, 0, 1'b0, 1'b0);

        // Write-with-start on slot 0.
        run(3, 0, 0, 1'b0, 1'b1);

        // Randomized runs.
        for (int k = 0; k < 14; k++) begin
            if (k % 3 == 0) load_random();
            cnt = int'($urandom_range(31, 1));
            n   = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
            h   = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n * SLOT, 1)) : 0;
            e   = ($urandom_range(2, 0) == 0)
                  ? int'($urandom_range((h > 0) ? h : n * SLOT, 1)) : 0;
            run(cnt, h, e, 1'($urandom), 1'($urandom));
        end

        // halt together with start in IDLE: no run.
        @(negedge clk);
        clear_queues();
        bus.start = 1'b1; bus.halt = 1'b1; bus.count = 5'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.halt = 1'b0;
        repeat (3 * SLOT) @(negedge clk);
        check("halt_start_pulses", 32'(q_pcyc.size()), 32'd0);
        check("halt_start_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of the second pulse.
        mon_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.count = 5'd8;
        repeat (SLOT + 2) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("mid_pulse", 32'(bus.alu_enable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outs", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_idle", 32'(all_outs()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
